fifo_spi_master: RTL
====================

# fifo_spi_master

Fabric-side consumer of the host input FIFO (FIFO A) and producer for the host output FIFO (FIFO B), running in the 50 MHz `CLK` domain. It pops one 32-bit word from FIFO A and shifts it MSB-first to the chip over a mode-0 SPI master. It captures the simultaneous MISO word and pushes it into FIFO B for host readback. This block replaces the test stub between the two FIFOs and drives the chip's `spi_*` pins.

## Interface
Parameters:
- `DATA_W`, default 32: SPI frame length in bits; equals the FIFO word width.
- `CLK_DIV`, default 4: `spi_sck` half-period in `CLK` cycles; must be ≥ 2. SCK frequency = CLK/(2·CLK_DIV).

Ports:
- `CLK`  in  1  system clock (CLK50M).
- `rst_n`  in  1  asynchronous active-low reset.
- `FIFOA_OUT`  in  DATA_W  FIFO A read data, valid 1 cycle after `FIFOA_ren` (standard, non-FWFT).
- `FIFOA_empty`  in  1  FIFO A empty.
- `FIFOA_ren`  out  1  FIFO A read strobe, 1-cycle pulse.
- `FIFOB_full`  in  1  FIFO B full.
- `FIFOB_IN`  out  DATA_W  word written to FIFO B.
- `FIFOB_wen`  out  1  FIFO B write strobe, 1-cycle pulse.
- `spi_sck`  out  1  SPI clock, idle low.
- `spi_cs`  out  1  chip select, active low.
- `spi_mosi`  out  1  master out.
- `spi_miso`  in  1  master in; treated as synchronous to `spi_sck` with no extra synchronizer.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Reset values: `spi_cs`=1, `spi_sck`=0, `spi_mosi`=0, `FIFOA_ren`=0, `FIFOB_wen`=0, `FIFOB_IN`=0, `busy`=0. The FSM is in IDLE and all counters are 0.
- FSM states: IDLE → FETCH → LOAD → SETUP → SHIFT → HOLD → PUSH → IDLE.
- IDLE: if `!FIFOA_empty`, go to FETCH.
- FETCH: assert `FIFOA_ren` for exactly one cycle, then go to LOAD.
- LOAD: latch `FIFOA_OUT` into the TX shift register. Drive `spi_mosi` = bit DATA_W-1. Drive `spi_cs`=0. Go to SETUP.
- SETUP: hold for CLK_DIV cycles with `spi_sck`=0, then go to SHIFT.
- SHIFT: repeat DATA_W bit periods.
  - Each bit period is CLK_DIV cycles with `spi_sck` high, then CLK_DIV cycles with `spi_sck` low.
  - On the rising edge of `spi_sck`, sample `spi_miso` into the RX register LSB (left-shift).
  - On the falling edge of `spi_sck`, advance `spi_mosi` to the next lower bit.
  - After the last falling edge, go to HOLD.
- HOLD: hold for CLK_DIV cycles with `spi_cs`=0, then drive `spi_cs`=1 and `spi_mosi`=0 and go to PUSH.
- PUSH: wait while `FIFOB_full`=1; the SPI pins stay idle during the wait. When not full, drive `FIFOB_IN` = RX word and pulse `FIFOB_wen` for 1 cycle, then go to IDLE.
- RX word format: the first MISO bit received lands in bit DATA_W-1.
- Back-to-back words: IDLE is re-entered for 1 cycle between frames. `spi_cs` is therefore high for ≥ 1 + 1 + 1 cycles (PUSH, IDLE, FETCH) between frames.
- Reset mid-frame: all outputs return to their reset values at once. The frame is aborted. The popped FIFO A word is lost and nothing is written to FIFO B.
- FIFO A is never read while `FIFOA_empty`=1. FIFO B is never written while `FIFOB_full`=1.

## Timing
- Mode 0 (CPOL=0, CPHA=0). MOSI is stable ≥ CLK_DIV cycles before each rising SCK edge.
- Frame latency, from the FETCH cycle to `FIFOB_wen` with FIFO B not full: 1 (FETCH) + 1 (LOAD) + CLK_DIV + 2·CLK_DIV·DATA_W + CLK_DIV + 1 (PUSH) cycles.
  - Defaults: 1 + 1 + 4 + 256 + 4 + 1 = 267 cycles.
- All outputs are registered; no combinational path exists from inputs to outputs.
- `spi_sck` toggles only while `spi_cs`=0. Exactly DATA_W rising edges occur per frame.

## Configuration
- `SPI_LOOPBACK_EN`:
  - Defined: `spi_miso` is ignored and the RX sampler takes the internal `spi_mosi` register. The FIFO B word then equals the FIFO A word, which allows host-only bring-up without the chip. External `spi_*` outputs still toggle normally.
  - Undefined: RX samples the `spi_miso` pin.

## Test plan
- Reset, then release with FIFO A empty → `busy`=0, `spi_cs`=1, `spi_sck`=0, and no `FIFOA_ren` for 1000 cycles.
- Push 0xA5C3_0F81 into FIFO A; the SPI slave model returns 0x1234_5678 → MOSI bit stream equals 0xA5C3_0F81 MSB-first. Exactly 32 SCK rising edges. FIFO B receives 0x1234_5678. `FIFOB_wen` occurs 267 cycles after `FIFOA_ren`.
- Three words back-to-back (0x0000_0001, 0xFFFF_FFFF, 0x8000_0000) → three separate CS-low frames, each with `spi_cs` high ≥ 3 cycles between them. FIFO B holds the three slave responses in order.
- Hold `FIFOB_full`=1 at the end of a frame for 50 cycles → `FIFOB_wen` stays 0, SPI pins stay idle, no new FETCH occurs. The write happens 1 cycle after full deasserts.
- Assert `rst_n`=0 during bit 10 of a frame → `spi_cs`=1 and `spi_sck`=0 immediately. No FIFO B write. After release, the next FIFO A word transfers correctly.
- With `SPI_LOOPBACK_EN` defined, write 0xDEAD_BEEF → FIFO B reads 0xDEAD_BEEF regardless of the `spi_miso` pin (tie it to 0).

Source files
------------

// File: rtl/fifo_spi_master.sv
// fifo_spi_master: pops words from FIFO A, shifts them MSB-first over a mode-0 SPI master
// and pushes the captured MISO word into FIFO B. Define SPI_LOOPBACK_EN to sample MOSI instead of MISO.
module fifo_spi_master #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] FIFOA_OUT,
  input  logic              FIFOA_empty,
  output logic              FIFOA_ren,
  input  logic              FIFOB_full,
  output logic [DATA_W-1:0] FIFOB_IN,
  output logic              FIFOB_wen,
  output logic              spi_sck,
  output logic              spi_cs,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              busy
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETUP, SHIFT, HOLD, PUSH} state_t;

  state_t            state, next_state;
  logic [DIV_W-1:0]  div_cnt, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0] tx_shift, tx_shift_d;
  logic [DATA_W-1:0] rx_shift, rx_shift_d;
  logic [DATA_W-1:0] fifob_in_d;
  logic              ren_d, wen_d, sck_d, cs_d, mosi_d, busy_d;
  logic              rx_bit;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rx_bit      = spi_mosi;
`else
  assign rx_bit = spi_miso;
`endif

  // Every output is a flop; the comb block only computes next values.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      FIFOB_IN  <= '0;
      FIFOA_ren <= 1'b0;
      FIFOB_wen <= 1'b0;
      spi_sck   <= 1'b0;
      spi_cs    <= 1'b1;
      spi_mosi  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      div_cnt   <= div_cnt_d;
      bit_cnt   <= bit_cnt_d;
      tx_shift  <= tx_shift_d;
      rx_shift  <= rx_shift_d;
      FIFOB_IN  <= fifob_in_d;
      FIFOA_ren <= ren_d;
      FIFOB_wen <= wen_d;
      spi_sck   <= sck_d;
      spi_cs    <= cs_d;
      spi_mosi  <= mosi_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    next_state = state;
    div_cnt_d  = div_cnt;
    bit_cnt_d  = bit_cnt;
    tx_shift_d = tx_shift;
    rx_shift_d = rx_shift;
    fifob_in_d = FIFOB_IN;
    ren_d      = 1'b0;
    wen_d      = 1'b0;
    sck_d      = spi_sck;
    cs_d       = spi_cs;
    mosi_d     = spi_mosi;

    unique case (state)
      IDLE: begin
        if (!FIFOA_empty) begin
          next_state = FETCH;
          ren_d      = 1'b1;
        end
      end
      FETCH: next_state = LOAD;
      LOAD: begin
        // tx_shift holds the bits still to be sent after the one on MOSI
        tx_shift_d = {FIFOA_OUT[DATA_W-2:0], 1'b0};
        mosi_d     = FIFOA_OUT[DATA_W-1];
        cs_d       = 1'b0;
        div_cnt_d  = '0;
        bit_cnt_d  = '0;
        next_state = SETUP;
      end
      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_d  = '0;
          sck_d      = 1'b1;
          rx_shift_d = {rx_shift[DATA_W-2:0], rx_bit};
          next_state = SHIFT;
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_cnt_d = div_cnt + 1'b1;
        end else begin
          div_cnt_d = '0;
          if (spi_sck) begin
            sck_d      = 1'b0;
            mosi_d     = tx_shift[DATA_W-1];
            tx_shift_d = {tx_shift[DATA_W-2:0], 1'b0};
          end else if (bit_cnt == BIT_LAST) begin
            next_state = HOLD;
          end else begin
            sck_d      = 1'b1;
            rx_shift_d = {rx_shift[DATA_W-2:0], rx_bit};
            bit_cnt_d  = bit_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
          cs_d       = 1'b1;
          mosi_d     = 1'b0;
          next_state = PUSH;
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      PUSH: begin
        if (!FIFOB_full) begin
          wen_d      = 1'b1;
          fifob_in_d = rx_shift;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    busy_d = (next_state != IDLE);
  end

endmodule
